ack_nak_tracker: RTL

Receive-side companion to the data link layer replay buffer. It decodes incoming ACK/NAK DLLPs and checks their sequence numbers against the transmit window. It drives the replay buffer's `ack_nak`, `seq` and `tim_out` inputs, owns the replay timer and the REPLAY_NUM counter, and tells the transmit path when the sequence window is full.

---
 rtl/dll_pkg.sv | 11 +
 rtl/replay_timer.sv | 20 ++
 rtl/ack_nak_tracker.sv | 95 +++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// dll_pkg: shared ACK/NAK types, DLLP type codes and modulo sequence helper.
package dll_pkg;
  localparam int DEF_SEQ_W = 12;
  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;
  typedef enum logic [1:0] {NONE = 2'b00, ACK = 2'b01, NAK = 2'b10} ack_nak_t;
  // Callers truncate the result to their sequence width to get modulo 2^SEQ_W.
  function automatic logic [31:0] seq_dist(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/replay_timer.sv
// replay_timer: counts while enabled, freezes on hold, flags the last count before expiry.
module replay_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  logic run;
  assign run = enable && !hold;
  assign expire = run && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clear ? '0 : run ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ack_nak_tracker.sv
// ack_nak_tracker: decodes ACK/NAK DLLPs against the transmit window, owns the
// replay timer and REPLAY_NUM, and drives the replay buffer's ack_nak/seq/tim_out.
module ack_nak_tracker
  import dll_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_seq_inc,
  input  logic             dllp_valid,
  input  logic             dllp_crc_ok,
  input  logic [31:0]      dllp_body,
  input  logic             replay_busy,
  output logic [1:0]       ack_nak,
  output logic [SEQ_W-1:0] seq,
  output logic             tim_out,
  output logic             retrain,
  output logic             dllp_err,
  output logic             tx_block,
  output logic [SEQ_W-1:0] next_tx_seq,
  output logic [SEQ_W-1:0] acked_seq
);
  typedef enum logic [1:0] {IDLE, ARMED, REPLAY} state_t;
  state_t state, state_n;
  ack_nak_t an_n;
  logic [SEQ_W-1:0] s, in_flight, outstanding, d, next_seq_n, acked_n, out_n;
  logic [7:0] dtype;
  logic [1:0] replay_num;
  logic busy_q, is_nak, good, fwd, dup, ack_fwd, nak, expire, timeout, bump, inc_ok;
  logic unused_body;
  assign unused_body = ^dllp_body[23:SEQ_W];
  assign dtype = dllp_body[31:24];
  assign s = dllp_body[SEQ_W-1:0];
  assign in_flight = SEQ_W'(seq_dist(32'(next_tx_seq), 32'(acked_seq)));
  assign outstanding = in_flight - 1'b1;
  assign d = SEQ_W'(seq_dist(32'(next_tx_seq), 32'(s))) - 1'b1;
  // Half the sequence space in flight is exactly the MSB of the distance.
  assign tx_block = in_flight[SEQ_W-1];
  assign is_nak = dtype == DLLP_NAK;
  assign good = dllp_valid && dllp_crc_ok && (is_nak || dtype == DLLP_ACK);
  assign fwd = good && d < outstanding;
  assign dup = good && s == acked_seq;
  assign ack_fwd = fwd && !is_nak;
  assign nak = (fwd || dup) && is_nak;
  assign timeout = expire && !ack_fwd && !nak;
  assign bump = nak || timeout;
  assign inc_ok = tx_seq_inc && !tx_block;
  assign next_seq_n = next_tx_seq + SEQ_W'(inc_ok);
  assign acked_n = fwd ? s : acked_seq;
  assign out_n = SEQ_W'(seq_dist(32'(next_seq_n), 32'(acked_n))) - 1'b1;
  assign an_n = ack_fwd ? ACK : nak ? NAK : NONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = inc_ok ? ARMED : IDLE;
      ARMED:   state_n = bump ? REPLAY : (ack_fwd && out_n == '0) ? IDLE : ARMED;
      REPLAY:  state_n = (busy_q && !replay_busy) ? ((out_n == '0) ? IDLE : ARMED) : REPLAY;
      default: state_n = IDLE;
    endcase
  end
  replay_timer #(.TIMEOUT(REPLAY_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ARMED || ack_fwd || nak || expire),
    .hold   (replay_busy),
    .enable (state == ARMED),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      next_tx_seq <= '0;
      acked_seq <= '1;
      replay_num <= '0;
      busy_q <= 1'b0;
      ack_nak <= NONE;
      seq <= '0;
      tim_out <= 1'b0;
      retrain <= 1'b0;
      dllp_err <= 1'b0;
    end else begin
      state <= state_n;
      next_tx_seq <= next_seq_n;
      acked_seq <= acked_n;
      replay_num <= ack_fwd ? 2'd0 : replay_num + 2'(bump);
      busy_q <= replay_busy;
      ack_nak <= an_n;
      seq <= (ack_fwd || nak) ? s : seq;
      tim_out <= timeout;
      retrain <= bump && replay_num == 2'd3;
      dllp_err <= dllp_valid && !(fwd || dup);
    end
endmodule
